// File: rtl/pe_nic.sv
// pe_nic: processor-side network interface for one router port.
//
// Holds a single-entry output buffer (processor -> router) and a single-entry
// input buffer (router -> processor), each with a full flag.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   addr[1:0]         register select: 00 in buf, 01 out status, 10 out buf, 11 in status
//   d_in[63:0]        processor write data
//   d_out[63:0]       processor read data (combinational)
//   nicEn, nicWrEn    access enable, 1 = write / 0 = read
//   phase_external    router phase; sends only allowed while high
//   net_so/net_ro     send strobe to router / router ready
//   net_do[63:0]      packet to router
//   net_si/net_ri     strobe from router / ready to router
//   net_di[63:0]      packet from router
//
// Optional feature: define PE_NIC_HOP_ENCODE_EN to store the hx/hy hop fields
// of written packets as saturating thermometer codes.

module pe_nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [63:0] d_in,
  output logic [63:0] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  input  logic        phase_external,
  output logic        net_so,
  input  logic        net_ro,
  output logic [63:0] net_do,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [63:0] net_di
);

  localparam logic [1:0] AddrInBuf     = 2'b00;
  localparam logic [1:0] AddrOutStatus = 2'b01;
  localparam logic [1:0] AddrOutBuf    = 2'b10;
  localparam logic [1:0] AddrInStatus  = 2'b11;

  logic [63:0] out_buf_q, out_buf_d;
  logic        out_full_q, out_full_d;
  logic [63:0] in_buf_q, in_buf_d;
  logic        in_full_q, in_full_d;

  logic        wr_out;
  logic        rd_in;
  logic        send;
  logic        capture;
  logic [63:0] wr_data;

`ifdef PE_NIC_HOP_ENCODE_EN
  function automatic logic [3:0] therm(input logic [3:0] v);
    logic [3:0] t;
    unique case (v)
      4'd0:    t = 4'b0000;
      4'd1:    t = 4'b0001;
      4'd2:    t = 4'b0011;
      4'd3:    t = 4'b0111;
      default: t = 4'b1111;
    endcase
    return t;
  endfunction

  assign wr_data = {d_in[63:56], therm(d_in[55:52]), therm(d_in[51:48]), d_in[47:0]};
`else
  assign wr_data = d_in;
`endif

  // Outputs are forced low during reset regardless of register contents.
  assign net_so  = ~reset & out_full_q & phase_external;
  assign net_ri  = ~reset & ~in_full_q;
  assign net_do  = (~reset & out_full_q) ? out_buf_q : 64'd0;

  assign send    = net_so & net_ro;
  assign capture = net_si & net_ri;
  // Write is gated on the pre-edge flag, so a same-edge send wins.
  assign wr_out  = nicEn & nicWrEn & (addr == AddrOutBuf) & ~out_full_q;
  assign rd_in   = nicEn & ~nicWrEn & (addr == AddrInBuf);

  always_comb begin
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;

    if (wr_out) begin
      out_buf_d  = wr_data;
      out_full_d = 1'b1;
    end else if (send) begin
      out_full_d = 1'b0;
    end

    // capture needs in_full=0, clear needs in_full=1: never both.
    if (capture) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end else if (rd_in && in_full_q) begin
      in_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_buf_q  <= 64'd0;
      out_full_q <= 1'b0;
      in_buf_q   <= 64'd0;
      in_full_q  <= 1'b0;
    end else begin
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
    end
  end

  always_comb begin
    d_out = 64'd0;
    if (!reset && nicEn) begin
      unique case (addr)
        AddrInBuf:     d_out = in_buf_q;
        AddrOutStatus: d_out = {63'd0, out_full_q};
        AddrOutBuf:    d_out = out_buf_q;
        AddrInStatus:  d_out = {63'd0, in_full_q};
        default:       d_out = 64'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_nic.sv
module tb_pe_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        phase_external;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference state: what the NIC should be holding right now.
  logic [63:0] m_out_buf, m_in_buf;
  logic        m_out_full, m_in_full;
  int unsigned m_sent;

  always #5 clk = ~clk;

  pe_nic dut (
    .clk            (clk),
    .reset          (reset),
    .addr           (addr),
    .d_in           (d_in),
    .d_out          (d_out),
    .nicEn          (nicEn),
    .nicWrEn        (nicWrEn),
    .phase_external (phase_external),
    .net_so         (net_so),
    .net_ro         (net_ro),
    .net_do         (net_do),
    .net_si         (net_si),
    .net_ri         (net_ri),
    .net_di         (net_di)
  );

  function automatic logic [63:0] model_store(input logic [63:0] w);
    logic [63:0] r;
    r = w;
`ifdef PE_NIC_HOP_ENCODE_EN
    begin
      int hx, hy;
      hx = int'(w[55:52]);
      hy = int'(w[51:48]);
      if (hx > 4) hx = 4;
      if (hy > 4) hy = 4;
      r[55:52] = 4'((1 << hx) - 1);
      r[51:48] = 4'((1 << hy) - 1);
    end
`endif
    return r;
  endfunction

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance the reference model across one rising edge using the pre-edge inputs.
  task automatic model_edge();
    logic do_send, do_wr, do_cap;
    if (reset) begin
      m_out_buf = '0; m_out_full = 0; m_in_buf = '0; m_in_full = 0;
    end else begin
      do_send = m_out_full && phase_external && net_ro;
      do_wr   = nicEn && nicWrEn && addr == 2'd2 && !m_out_full;
      do_cap  = net_si && !m_in_full;
      if (do_send) begin m_out_full = 0; m_sent++; end
      if (do_wr) begin m_out_buf = model_store(d_in); m_out_full = 1; end
      if (nicEn && !nicWrEn && addr == 2'd0 && m_in_full) m_in_full = 0;
      else if (do_cap) begin m_in_buf = net_di; m_in_full = 1; end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs and compare all of them against the model.
  task automatic chk();
    logic [63:0] e_dout;
    #1;
    e_dout = '0;
    if (!reset && nicEn) begin
      case (addr)
        2'd0: e_dout = m_in_buf;
        2'd1: e_dout = {63'd0, m_out_full};
        2'd2: e_dout = m_out_buf;
        default: e_dout = {63'd0, m_in_full};
      endcase
    end
    check64("net_so", {63'd0, net_so}, {63'd0, !reset && m_out_full && phase_external});
    check64("net_ri", {63'd0, net_ri}, {63'd0, !reset && !m_in_full});
    check64("net_do", net_do, (!reset && m_out_full) ? m_out_buf : 64'd0);
    check64("d_out", d_out, e_dout);
  endtask

  task automatic idle();
    nicEn = 0; nicWrEn = 0; addr = 2'd0; d_in = '0;
  endtask

  task automatic proc_wr(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1; nicWrEn = 1; addr = a; d_in = d;
  endtask

  task automatic proc_rd(input logic [1:0] a);
    nicEn = 1; nicWrEn = 0; addr = a; d_in = '0;
  endtask

  localparam logic [63:0] PktA = 64'h80110203000000AA;
  localparam logic [63:0] PktB = 64'h40000000DEADBEEF;

  initial begin
    int unsigned sent_before;
    m_out_buf = '0; m_in_buf = '0; m_out_full = 0; m_in_full = 0; m_sent = 0;
    reset = 1; idle(); phase_external = 0; net_ro = 0; net_si = 0; net_di = '0;
    #1;

    // Reset for two cycles, outputs held low meanwhile.
    tick(); chk();
    tick(); chk();
    reset = 0; chk();
    check64("ri_after_reset", {63'd0, net_ri}, 64'd1);
    check64("so_after_reset", {63'd0, net_so}, 64'd0);
    proc_rd(2'd1); chk();
    check64("out_status_reset", d_out, 64'd0);
    proc_rd(2'd3); chk();
    check64("in_status_reset", d_out, 64'd0);

    // Writes to non-buffer addresses do nothing.
    proc_wr(2'd0, 64'hFFFF); tick();
    proc_wr(2'd1, 64'hFFFF); tick();
    proc_wr(2'd3, 64'hFFFF); tick();
    idle(); chk();

    // Basic send with phase high: one-cycle latency, drop after transfer.
    phase_external = 1; net_ro = 1;
`ifdef PE_NIC_HOP_ENCODE_EN
    proc_wr(2'd2, 64'h00020101ABCD0001);
`else
    proc_wr(2'd2, 64'h00030101ABCD0001);
`endif
    tick(); idle(); chk();
    check64("send_so", {63'd0, net_so}, 64'd1);
    check64("send_do", net_do, 64'h00030101ABCD0001);
    tick(); chk();
    check64("send_so_drop", {63'd0, net_so}, 64'd0);

    // Phase low blocks sending.
    phase_external = 0; net_ro = 1; proc_wr(2'd2, PktA); tick(); idle();
    for (int i = 0; i < 3; i++) begin
      chk();
      check64("phase_block_so", {63'd0, net_so}, 64'd0);
      tick();
    end
    proc_rd(2'd1); chk();
    check64("phase_block_full", d_out, 64'd1);
    phase_external = 1; chk();
    check64("phase_rise_so", {63'd0, net_so}, 64'd1);
    sent_before = m_sent;
    tick(); chk();
    check64("phase_sent", 64'(m_sent - sent_before), 64'd1);

    // Write while full is dropped.
    net_ro = 0; proc_wr(2'd2, PktA); tick(); chk();
    proc_wr(2'd2, PktB); tick();
    proc_rd(2'd2); chk();
    check64("drop_holds_a", d_out, PktA);
    idle(); net_ro = 1; chk();
    check64("drop_net_do_a", net_do, PktA);
    tick(); proc_rd(2'd1); chk();
    check64("drop_status_clear", d_out, 64'd0);

    // Same-edge write and send: send completes, write dropped.
    net_ro = 0; proc_wr(2'd2, PktA); tick();
    net_ro = 1; proc_wr(2'd2, PktB); tick(); idle(); chk();
    check64("collide_empty", {63'd0, net_so}, 64'd0);

    // Receive path.
    net_ro = 0; net_si = 1; net_di = 64'h1234; tick(); chk();
    proc_rd(2'd3); chk();
    check64("rx_status", d_out, 64'd1);
    check64("rx_ri_low", {63'd0, net_ri}, 64'd0);
    idle(); net_di = 64'h5678; tick();
    net_si = 0; proc_rd(2'd0); chk();
    check64("rx_data", d_out, 64'h1234);
    tick(); idle(); chk();
    check64("rx_ri_back", {63'd0, net_ri}, 64'd1);

    // Reset mid-operation discards both entries.
    phase_external = 0; proc_wr(2'd2, PktA); net_si = 1; net_di = 64'h99; tick();
    idle(); net_si = 0; net_ro = 1; reset = 1; chk(); tick();
    reset = 0; sent_before = m_sent; chk();
    check64("rst_so", {63'd0, net_so}, 64'd0);
    check64("rst_ri", {63'd0, net_ri}, 64'd1);
    proc_rd(2'd1); chk();
    check64("rst_out_flag", d_out, 64'd0);
    proc_rd(2'd3); chk();
    check64("rst_in_flag", d_out, 64'd0);
    phase_external = 1; chk();
    check64("rst_no_send", {63'd0, net_so}, 64'd0);
    tick(); check64("rst_no_transfer", 64'(m_sent - sent_before), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 39) == 0);
      nicEn          = 1'($urandom);
      nicWrEn        = 1'($urandom);
      addr           = 2'($urandom);
      d_in           = {$urandom, $urandom};
      phase_external = 1'($urandom);
      net_ro         = 1'($urandom);
      net_si         = 1'($urandom);
      net_di         = {$urandom, $urandom};
      chk();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pe_nic.md
PE_NIC -- requirements
Module: pe_nic

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
REQ-002 SHALL expose the following processor-side ports.
- addr  in  2  register select: 00 input buffer, 01 output status, 10 output buffer, 11 input status.
- d_in  in  64  write data.
- d_out  out  64  read data.
- nicEn  in  1  access enable.
- nicWrEn  in  1  1 = write, 0 = read.
REQ-003 SHALL expose the following router-side ports.
- phase_external  in  1  router external phase; sending is allowed only while this is 1.
- net_so  out  1  send strobe to the router's pe_si.
- net_ro  in  1  router ready, from the router's pe_ri.
- net_do  out  64  packet to the router's pe_di.
- net_si  in  1  send strobe from the router's pe_so.
- net_ri  out  1  ready to the router's pe_ro.
- net_di  in  64  packet from the router's pe_do.
REQ-004 Packet format SHALL be [63] vc, [62] dx, [61] dy, [60:56] rsv, [55:52] hx, [51:48] hy, [47:40] sx, [39:32] sy, [31:0] payload.

Function
REQ-005 SHALL hold one 64-bit output buffer with an out_full flag and one 64-bit input buffer with an in_full flag.
REQ-006 A write (nicEn=1, nicWrEn=1, addr=10) with out_full=0 SHALL load d_in into the output buffer and set out_full at that clock edge.
REQ-007 A write to the output buffer while out_full=1 SHALL be dropped, leaving the buffer and flag unchanged.
REQ-008 Writes to addr 00, 01 or 11 SHALL have no effect.
REQ-009 net_so SHALL equal out_full AND phase_external, combinationally.
REQ-010 net_do SHALL present the output buffer contents whenever out_full=1, and 0 otherwise.
REQ-011 The output transfer SHALL occur at a rising edge where net_so=1 and net_ro=1; out_full SHALL clear at that edge, so net_so drops in the next cycle.
REQ-012 If a processor write and a send occur at the same edge, the send SHALL complete and the write SHALL be dropped, because the write is gated on the pre-edge out_full value.
REQ-013 net_ri SHALL equal NOT in_full when not in reset.
REQ-014 At a rising edge where net_si=1 and net_ri=1, net_di SHALL be captured into the input buffer and in_full SHALL be set.
REQ-015 A read (nicEn=1, nicWrEn=0, addr=00) SHALL present the input buffer on d_out and clear in_full at that edge.
- Reading while in_full=0 returns the stale buffer contents and has no side effect.
REQ-016 A capture and a read-clear SHALL never coincide at one edge, since net_ri=0 whenever in_full=1; a new packet is therefore accepted no earlier than one cycle after the read.
REQ-017 d_out SHALL be combinational:
- addr 01 gives {63'b0, out_full};
- addr 11 gives {63'b0, in_full};
- addr 10 gives the output buffer contents;
- nicEn=0 gives 0.
REQ-018 Latency from a processor write to net_so=1 SHALL be 1 cycle when phase_external=1; otherwise net_so rises in the first cycle with phase_external=1.

Reset
REQ-019 While reset=1 the block SHALL drive net_so=0, net_ri=0, net_do=0 and d_out=0.
- At each edge in reset it SHALL clear out_full, in_full and both buffers.
REQ-020 Asserting reset mid-operation SHALL discard any pending packet without transferring it.
- In the first cycle after reset deasserts, net_ri SHALL be 1 and net_so SHALL be 0.

Configuration
REQ-021 With macro PE_NIC_HOP_ENCODE_EN defined, a write to addr 10 SHALL store hx and hy as thermometer codes derived from their binary values:
- 0→0000, 1→0001, 2→0011, 3→0111, 4→1111;
- values 5 to 15 saturate to 1111;
- all other fields SHALL be stored unchanged.
REQ-022 Without PE_NIC_HOP_ENCODE_EN, the write data SHALL be stored verbatim.

Verification
REQ-023 Reset for 2 cycles, then release -> net_ri=1, net_so=0; reads of addr 01 and 11 both return 0.
REQ-024 With phase_external=1, write 64'h00030101ABCD0001 to addr 10, then hold net_ro=1 -> net_so=1 and net_do=64'h00030101ABCD0001 in the next cycle; net_so=0 after the transfer edge. With PE_NIC_HOP_ENCODE_EN, write 64'h00020101ABCD0001 -> net_do=64'h00030101ABCD0001.
REQ-025 Write a packet with phase_external=0 and net_ro=1 for 3 cycles -> net_so stays 0 and addr 01 reads 1; on raising phase_external, net_so=1 and the transfer completes.
REQ-026 Write packet A, hold net_ro=0, then write packet B -> the buffer holds A; after net_ro rises, net_do=A and addr 01 reads 0.
REQ-027 Drive net_si=1 with net_di=64'h1234 -> addr 11 reads 1 and net_ri=0; a second packet with net_si=1 is not captured; reading addr 00 returns 64'h1234; net_ri=1 in the next cycle.
REQ-028 With out_full=1 and in_full=1, assert reset for 1 cycle -> both flags read 0, net_so=0 and net_ri=1 after release, and no transfer occurs even if net_ro=1.
